// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sweeps a RAM address range and streams the words out on valid/ready
module ram_stream_reader #(
  parameter int DATA_WDTH = 32,
  parameter int ADDR_WDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_WDTH-1:0] base_addr,
  input  logic [ADDR_WDTH:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_we,
  output logic [ADDR_WDTH-1:0] ram_addr,
  input  logic [DATA_WDTH-1:0] ram_dout,
  output logic [DATA_WDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t               state_q;
  logic [ADDR_WDTH-1:0] addr_q, ram_addr_q;
  logic [ADDR_WDTH:0]   rem_q;
  logic                 inflight_q, inflight_last_q;
  logic [DATA_WDTH-1:0] d0_q, d1_q;
  logic                 l0_q, l1_q;
  logic [1:0]           cnt_q, cnt_d, slot_d;
  logic                 busy_q, done_q;
  logic                 pop, push, issue;
  // Handshake, capture and credit-gated read issue; the credit keeps buffer plus in-flight read within two slots
  always_comb begin
    pop    = (cnt_q != 2'd0) && m_ready;
    push   = inflight_q;
    cnt_d  = cnt_q + 2'(push) - 2'(pop);
    slot_d = cnt_q - 2'(pop);
    issue  = (state_q == RUN) && ((cnt_q + 2'(inflight_q) - 2'(pop)) < 2'd2);
  end
  // Command FSM, read issue pipeline and 2-entry output buffer whose head drives the stream
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      ram_addr_q      <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      d0_q            <= '0;
      d1_q            <= '0;
      l0_q            <= 1'b0;
      l1_q            <= 1'b0;
      cnt_q           <= 2'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        ram_addr_q      <= addr_q;
        addr_q          <= addr_q + ADDR_WDTH'(1);
        rem_q           <= rem_q - (ADDR_WDTH+1)'(1);
        inflight_last_q <= rem_q == (ADDR_WDTH+1)'(1);
      end
      case (state_q)
        IDLE: if (start) begin
          if (length != '0) begin
            addr_q  <= base_addr;
            rem_q   <= length;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else done_q <= 1'b1;
        end
        RUN: if (issue && rem_q == (ADDR_WDTH+1)'(1)) state_q <= DRAIN;
        DRAIN: if (pop && l0_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
      cnt_q <= cnt_d;
      if (pop) begin
        d0_q <= d1_q;
        l0_q <= l1_q;
      end
      if (push && slot_d == 2'd0) begin
        d0_q <= ram_dout;
        l0_q <= inflight_last_q;
      end
      if (push && slot_d == 2'd1) begin
        d1_q <= ram_dout;
        l1_q <= inflight_last_q;
      end
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_we   = 1'b0;
  assign ram_addr = ram_addr_q;
  assign m_data   = d0_q;
  assign m_valid  = cnt_q != 2'd0;
  assign m_last   = (cnt_q != 2'd0) && l0_q;
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed checks of the RAM stream reader against a preloaded RAM model
module tb_ram_stream_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic [11:0] length = '0;
  logic        busy, done, ram_we, m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [10:0] ram_addr;
  logic [31:0] ram_dout, m_data;
  logic [31:0] mem [2048];
  int          tests = 0;
  int          fails = 0;

  ram_stream_reader #(.DATA_WDTH(32), .ADDR_WDTH(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;
  assign ram_dout = mem[ram_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [10:0] b, input logic [11:0] l);
    start = 1'b1;
    base_addr = b;
    length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [10:0] base, input int len, input logic [15:0] pat,
                     input int stop_at, input int poke_at, input bit full);
    int k = 0;
    int first_i = -1;
    int last_i = -1;
    bit pv = 1'b0;
    bit pr = 1'b0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    logic [10:0] a;
    for (int i = 0; i < 3 * len + 20 && k < stop_at; i++) begin
      m_ready = pat[i % 16];
      start = (i == poke_at);
      if (i == poke_at) begin
        base_addr = 11'h300;
        length = 12'd2;
      end
      if (pv && !pr) chk("stall_hold", 64'({m_valid, m_last, m_data}), 64'({1'b1, pl, pd}));
      if (m_valid && first_i < 0) first_i = i;
      if (m_valid && m_ready) begin
        a = base + 11'(k);
        chk("word", 64'({m_last, m_data}), 64'({k == len - 1, 32'(a)}));
        k++;
        last_i = i;
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      pl = m_last;
      @(negedge clk);
    end
    start = 1'b0;
    chk("word_count", 64'(k), 64'(stop_at));
    if (stop_at == len) begin
      chk("done_busy_valid", 64'({done, busy, m_valid}), 64'(3'b100));
      @(negedge clk);
      chk("done_single", 64'(done), 64'(0));
      if (full) chk("latency", 64'({first_i, last_i}), 64'({32'd2, 32'(len + 1)}));
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i);
    repeat (2) @(negedge clk);
    chk("reset_ctl", 64'({busy, done, m_valid, m_last, ram_we}), 64'(0));
    chk("reset_dat", 64'({ram_addr, m_data}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    cmd(11'h010, 12'd4);
    chk("busy_after_start", 64'({busy, m_valid}), 64'(2'b10));
    run(11'h010, 4, 16'hFFFF, 4, -1, 1'b1);
    cmd(11'h010, 12'd4);
    run(11'h010, 4, 16'b1010_0101_1010_1001, 4, -1, 1'b0);
    cmd(11'h7FE, 12'd4);
    run(11'h7FE, 4, 16'hFFFF, 4, -1, 1'b1);
    cmd(11'h123, 12'd0);
    chk("len0_done", 64'({done, busy, m_valid}), 64'(3'b100));
    @(negedge clk);
    chk("len0_after", 64'({done, busy, m_valid, ram_addr}), 64'({3'b000, 11'h001}));
    cmd(11'h000, 12'd2048);
    run(11'h000, 2048, 16'hFFFF, 2048, -1, 1'b1);
    cmd(11'h040, 12'd8);
    run(11'h040, 8, 16'hFFFF, 2, -1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_ctl", 64'({busy, done, m_valid, m_last, ram_we}), 64'(0));
    chk("midreset_dat", 64'({ram_addr, m_data}), 64'(0));
    repeat (3) begin
      @(negedge clk);
      chk("midreset_quiet", 64'({busy, done, m_valid}), 64'(0));
    end
    cmd(11'h100, 12'd1);
    run(11'h100, 1, 16'hFFFF, 1, -1, 1'b1);
    cmd(11'h200, 12'd6);
    run(11'h200, 6, 16'hFFFF, 6, 3, 1'b1);
    chk("ignored_start_idle", 64'({busy, m_valid}), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
